// File: rtl/sensor_dma_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// sensor_dma_fifo_ctrl
//   Sensor sample receive buffer with DMA watermark request.
//   Samples pushed by the sensor front end land in a first-word-fall-through
//   FIFO (2^FIFO_AW x DATAWIDTH). When the fill level reaches the programmed
//   watermark and DMA is enabled, DMA_Start_o is raised until the DMA engine
//   reports completion. A Wishbone register file exposes control, watermark,
//   sticky status, fill level and a saturating overrun counter.
//
// Ports
//   WBs_CLK_i / WBs_RSTn_i     clock, async active-low reset
//   WBs_ADR_i .. WBs_DAT_i     Wishbone slave inputs (register + DMA data space)
//   WBs_DAT_o                  register read data, combinational from address
//   WBs_DMA_DAT_o              FIFO head word
//   WBs_ACK_o                  one-cycle acknowledge for both spaces
//   Sensor_RD_Data_i/Push_i    sample and push strobe
//   Sensor_Enable_o            CTRL.SENS_EN
//   DMA_Done_i / DMA_Clr_i     DMA engine completion / enable clear
//   DMA_Start_o                DMA request
//   IRQ_o                      registered interrupt
// ----------------------------------------------------------------------------
module sensor_dma_fifo_ctrl #(
    parameter int          ADDRWIDTH     = 10,
    parameter int          DATAWIDTH     = 32,
    parameter int          FIFO_AW       = 9,
    parameter logic [31:0] DEVICE_ID     = 32'h0ADC0002,
    parameter logic [31:0] DEF_REG_VALUE = 32'hFABDEFAC
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RSTn_i,
    input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
    input  logic                 WBs_CYC_i,
    input  logic                 WBs_CYC_DMA_DAT_i,
    input  logic                 WBs_STB_i,
    input  logic                 WBs_WE_i,
    input  logic [3:0]           WBs_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0] WBs_DAT_i,
    output logic [DATAWIDTH-1:0] WBs_DAT_o,
    output logic [DATAWIDTH-1:0] WBs_DMA_DAT_o,
    output logic                 WBs_ACK_o,
    input  logic [DATAWIDTH-1:0] Sensor_RD_Data_i,
    input  logic                 Sensor_RD_Push_i,
    output logic                 Sensor_Enable_o,
    input  logic                 DMA_Done_i,
    input  logic                 DMA_Clr_i,
    output logic                 DMA_Start_o,
    output logic                 IRQ_o
);

    localparam int             DEPTH      = 1 << FIFO_AW;
    localparam int             LW         = FIFO_AW + 1;
    localparam logic [LW-1:0]  THRESH_RST = LW'(DEPTH / 2);

    localparam logic [ADDRWIDTH-1:0] A_ID     = ADDRWIDTH'(0);
    localparam logic [ADDRWIDTH-1:0] A_CTRL   = ADDRWIDTH'(1);
    localparam logic [ADDRWIDTH-1:0] A_THRESH = ADDRWIDTH'(2);
    localparam logic [ADDRWIDTH-1:0] A_STATUS = ADDRWIDTH'(3);
    localparam logic [ADDRWIDTH-1:0] A_LEVEL  = ADDRWIDTH'(4);
    localparam logic [ADDRWIDTH-1:0] A_OVRCNT = ADDRWIDTH'(5);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} dma_state_t;

    // Control / status state
    logic               sens_en, dma_en, ie_done, ie_ovr;
    logic               flush_q;
    logic [LW-1:0]      thresh;
    logic               done_flag, ovr_flag;
    logic [15:0]        ovr_cnt;
    dma_state_t         state;

    // FIFO state
    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]        level;

    logic               wr_en, wr_ctrl, wr_thresh, wr_status;
    logic               full, empty, push_ok, push_drop, pop;
    logic [LW-1:0]      watermark;

    assign wr_en     = WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~WBs_ACK_o;
    assign wr_ctrl   = wr_en & (WBs_ADR_i == A_CTRL)   & WBs_BYTE_STB_i[0];
    assign wr_thresh = wr_en & (WBs_ADR_i == A_THRESH);
    assign wr_status = wr_en & (WBs_ADR_i == A_STATUS) & WBs_BYTE_STB_i[0];

    // Fullness is taken from the registered level, i.e. before any pop
    // landing in the same cycle.
    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign push_ok   = Sensor_RD_Push_i & ~full;
    assign push_drop = Sensor_RD_Push_i & full;
    assign pop       = WBs_ACK_o & WBs_CYC_DMA_DAT_i & ~empty;
    assign watermark = (thresh == '0) ? LW'(1) : thresh;

    assign Sensor_Enable_o = sens_en;
    assign WBs_DMA_DAT_o   = mem[rd_ptr];

    // Acknowledge: one cycle after the strobe, never two in a row.
    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) WBs_ACK_o <= 1'b0;
        else             WBs_ACK_o <= (WBs_CYC_i | WBs_CYC_DMA_DAT_i) & WBs_STB_i & ~WBs_ACK_o;
    end

    // Control and watermark registers
    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            sens_en <= 1'b0;
            dma_en  <= 1'b0;
            ie_done <= 1'b0;
            ie_ovr  <= 1'b0;
            flush_q <= 1'b0;
            thresh  <= THRESH_RST;
        end else begin
            flush_q <= wr_ctrl & WBs_DAT_i[2];
            if (wr_ctrl) begin
                sens_en <= WBs_DAT_i[0];
                dma_en  <= WBs_DAT_i[1];   // a register write beats DMA_Clr_i
                ie_done <= WBs_DAT_i[3];
                ie_ovr  <= WBs_DAT_i[4];
            end else if (DMA_Clr_i) begin
                dma_en  <= 1'b0;
            end
            if (wr_thresh) begin
                for (int i = 0; i < LW; i++)
                    if (WBs_BYTE_STB_i[i/8]) thresh[i] <= WBs_DAT_i[i];
            end
        end
    end

    // Sticky status, overrun counter, interrupt. Set events beat W1C.
    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            done_flag <= 1'b0;
            ovr_flag  <= 1'b0;
            ovr_cnt   <= '0;
            IRQ_o     <= 1'b0;
        end else begin
            if (DMA_Done_i)                         done_flag <= 1'b1;
            else if (wr_status && WBs_DAT_i[0])     done_flag <= 1'b0;

            if (flush_q)                            ovr_flag <= 1'b0;
            else if (push_drop)                     ovr_flag <= 1'b1;
            else if (wr_status && WBs_DAT_i[1])     ovr_flag <= 1'b0;

            if (flush_q)                                  ovr_cnt <= '0;
            else if (push_drop && (ovr_cnt != 16'hFFFF))  ovr_cnt <= ovr_cnt + 16'd1;

            IRQ_o <= (done_flag & ie_done) | (ovr_flag & ie_ovr);
        end
    end

    // FIFO pointers and level; a flush overrides any push/pop that cycle.
    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_q) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push_ok) - LW'(pop);
        end
    end

    // Sample storage has no reset; only the pointers define valid contents.
    always_ff @(posedge WBs_CLK_i) begin
        if (push_ok && !flush_q) mem[wr_ptr] <= Sensor_RD_Data_i;
    end

    // DMA request FSM. DONE is a one-cycle gap so the request cannot
    // re-assert on the cycle right after completion.
    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            state       <= S_IDLE;
            DMA_Start_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dma_en && !flush_q && (level >= watermark)) begin
                        state       <= S_REQ;
                        DMA_Start_o <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (DMA_Done_i) begin
                        state       <= S_DONE;
                        DMA_Start_o <= 1'b0;
                    end else if (!dma_en || flush_q) begin
                        state       <= S_IDLE;
                        DMA_Start_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    DMA_Start_o <= 1'b0;
                end
            endcase
        end
    end

    // Register read mux
    always_comb begin
        WBs_DAT_o = DATAWIDTH'(DEF_REG_VALUE);
        case (WBs_ADR_i)
            A_ID:     WBs_DAT_o = DATAWIDTH'(DEVICE_ID);
            A_CTRL: begin
                WBs_DAT_o      = '0;
                WBs_DAT_o[4:0] = {ie_ovr, ie_done, 1'b0, dma_en, sens_en};
            end
            A_THRESH: begin
                WBs_DAT_o         = '0;
                WBs_DAT_o[LW-1:0] = thresh;
            end
            A_STATUS: begin
                WBs_DAT_o      = '0;
                WBs_DAT_o[1:0] = {ovr_flag, done_flag};
            end
            A_LEVEL: begin
                WBs_DAT_o              = '0;
                WBs_DAT_o[LW-1:0]      = level;
                WBs_DAT_o[DATAWIDTH-1] = full;
                WBs_DAT_o[DATAWIDTH-2] = empty;
            end
            A_OVRCNT: begin
                WBs_DAT_o       = '0;
                WBs_DAT_o[15:0] = ovr_cnt;
            end
            default: ;
        endcase
    end

endmodule
